// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - turns one-cycle sound requests into a timed four-step note sequence
// with a one-deep pending slot and a silent gap between melodies.
module melody_sequencer #(
  parameter int NOTE_TICKS = 250000,
  parameter int GAP_TICKS  = 50000,
  parameter int NUM_STEPS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [3:0] req_code,
  output logic [3:0] note_state,
  output logic [2:0] note_played,
  output logic       busy,
  output logic       done,
  output logic       dropped
);

  localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int CW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
  localparam logic [2:0]    LAST_STEP = 3'(NUM_STEPS);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [3:0]    note_state_d;
  logic [2:0]    note_played_d;
  logic          done_d, dropped_d;
  logic          pend_valid_q, pend_valid_d;
  logic [3:0]    pend_code_q, pend_code_d;

  logic          req_ok, req_coin;
  logic          q_valid, q_drop;
  logic [3:0]    q_code;

  assign req_ok   = req && (req_code != 4'd0) && (req_code <= 4'd6);
  assign req_coin = (req_code <= 4'd3);

  // Pending slot after accepting a request that arrives mid-melody; products outrank coins.
  always_comb begin
    q_valid = pend_valid_q;
    q_code  = pend_code_q;
    q_drop  = 1'b0;
    if (req_ok) begin
      if (!pend_valid_q) begin
        q_valid = 1'b1;
        q_code  = req_code;
      end else if ((pend_code_q <= 4'd3) || !req_coin) begin
        q_code = req_code;
        q_drop = 1'b1;
      end else begin
        q_drop = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q;
    note_state_d  = note_state;
    note_played_d = note_played;
    done_d        = 1'b0;
    dropped_d     = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_code_d   = pend_code_q;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          state_d       = PLAY;
          note_state_d  = req_code;
          note_played_d = 3'd1;
          tick_d        = '0;
        end
      end
      PLAY: begin
        pend_valid_d = q_valid;
        pend_code_d  = q_code;
        dropped_d    = q_drop;
        if (tick_q == NOTE_LAST) begin
          tick_d = '0;
          if (note_played < LAST_STEP) begin
            note_played_d = note_played + 3'd1;
          end else begin
            state_d       = GAP;
            note_state_d  = 4'd0;
            note_played_d = 3'd0;
            done_d        = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      GAP: begin
        if (tick_q == GAP_LAST) begin
          tick_d = '0;
          if (pend_valid_q) begin
            // Pending melody starts; a request on this same cycle refills the freed slot.
            state_d       = PLAY;
            note_state_d  = pend_code_q;
            note_played_d = 3'd1;
            pend_valid_d  = req_ok;
            pend_code_d   = req_ok ? req_code : 4'd0;
          end else if (req_ok) begin
            state_d       = PLAY;
            note_state_d  = req_code;
            note_played_d = 3'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tick_d       = tick_q + 1'b1;
          pend_valid_d = q_valid;
          pend_code_d  = q_code;
          dropped_d    = q_drop;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      note_state   <= 4'd0;
      note_played  <= 3'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dropped      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      note_state   <= note_state_d;
      note_played  <= note_played_d;
      busy         <= (state_d != IDLE);
      done         <= done_d;
      dropped      <= dropped_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
    end
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream driver of the item-based piezo tone stage.
- Turns one-cycle sound requests from the vending controller (coin accepted, product dispensed) into a timed four-step sequence on note_state / note_played.
- The piezo stage maps these outputs to tone pitches.
- Holds one pending request while a melody plays, and inserts a silent gap between consecutive melodies.

Parameters:
- NOTE_TICKS, 250000: clock cycles each note step is held (0.25 s at the 1 MHz system clock); must be ≥1.
- GAP_TICKS, 50000: silent cycles after step 4 before the next melody may start; must be ≥1.
- NUM_STEPS, 4: steps per melody; fixed to match the piezo stage's step encoding 1..4.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-low reset.
- req, input, 1: one-cycle request strobe.
- req_code, input, 4: melody code (1=100w, 2=500w, 3=1000w, 4=prod1, 5=prod2, 6=prod3); sampled only when req=1.
- note_state, output, 4: current melody code to the piezo stage; 0 = silent.
- note_played, output, 3: current step 1..4 to the piezo stage; 0 = silent.
- busy, output, 1: high whenever state ≠ IDLE.
- done, output, 1: one-cycle pulse at the end of step 4.
- dropped, output, 1: one-cycle pulse when a request is discarded.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all of the following clear to 0: note_state, note_played, busy, done, dropped, tick counter, pending valid, pending code.
- A request is valid when req=1 and req_code is in 1..6.
- req=1 with req_code 0 or 7..15 is ignored: no state change, no dropped pulse.
- States: IDLE, PLAY, GAP. All outputs are registered.
- IDLE:
  - Valid request sampled at edge k → from cycle k+1: state=PLAY, note_state=req_code, note_played=1, tick=0.
- PLAY:
  - tick counts 0..NOTE_TICKS-1; each step is visible for exactly NOTE_TICKS cycles.
  - At tick=NOTE_TICKS-1 with note_played<4: note_played increments and tick clears.
  - At tick=NOTE_TICKS-1 with note_played=4: next cycle state=GAP, note_state=0, note_played=0, done=1 for that single cycle, tick=0.
- GAP:
  - Outputs stay 0 for exactly GAP_TICKS cycles.
  - At tick=GAP_TICKS-1, if pending is valid: start the pending code exactly as from IDLE (note_played=1 next cycle) and clear pending.
  - Otherwise go to IDLE.
- Pending register (one deep): a valid request arriving in PLAY or GAP is stored in pending.
- Pending priority:
  - Pending empty → store the new code.
  - Pending holds a coin code (1..3) → a new code of any kind overwrites it; dropped=1.
  - Pending holds a product code (4..6) and the new code is a coin code → new code discarded; dropped=1.
  - Pending holds a product code and the new code is a product code → overwrite; dropped=1.
- Simultaneous events:
  - Valid req on the last GAP cycle with pending empty → that req starts directly (no dropped).
  - Valid req on the last GAP cycle with pending valid → pending starts; the new req goes into the emptied pending slot (no dropped).
  - Valid req on the last PLAY cycle → treated as arriving during PLAY (goes to pending).
- A request is never restarted mid-melody; the current melody always completes.
- Reset mid-melody → outputs clear to 0 immediately (asynchronously) and the pending request is lost.
- Counter width: ceil(log2(max(NOTE_TICKS, GAP_TICKS))) bits, unsigned compare; no wrap-around occurs because the counter clears at its terminal value.

Test Plan (NOTE_TICKS=4, GAP_TICKS=2):
- Reset release, then req=1 with code=2 at cycle 0 → note_state=2 for cycles 1..16; note_played=1,2,3,4 each for 4 cycles; cycle 17: outputs 0, done=1; cycles 17-18 GAP (busy=1); cycle 19 busy=0.
- Code 1 playing; req code 5 at cycle 3, req code 2 at cycle 6 → dropped=1 at cycle 7; after the gap, code 5 plays starting at cycle 19.
- Code 4 playing; req code 1 at cycle 3, req code 6 at cycle 8 → dropped=1 at cycle 9; code 6 starts at cycle 19.
- req with code 0 and req with code 9 while idle → no output change, busy=0, dropped=0.
- Code 3 playing with code 1 pending; req code 2 on cycle 18 (last GAP cycle) → code 1 starts at cycle 19; code 2 plays after the next gap (starts cycle 37).
- rst=0 asserted at cycle 10 during step 3 with pending valid → note_state, note_played, busy cleared immediately; after release, no melody plays without a new req.
